// File: rtl/instr_loader.sv
// Packs a valid/ready byte stream into 18-bit instruction words and writes them to instruction memory from address 0.
// Latency: a word is written in the cycle after its 3rd byte is accepted; done follows one cycle after the last write.
// Backpressure: in_ready is high only in RECV, so upstream holds bytes during WRITE, DONE and IDLE.
//
// Ports:
//   clk, rst_n      clock (rising edge) and async active-low reset
//   start           1-cycle load request; ignored while busy
//   word_count      words to load, sampled with start and clamped to the memory depth
//   in_data/in_valid/in_ready  byte stream, transfer on in_valid & in_ready
//   mem_wr_en/mem_wr_addr/mem_wr_data  instruction memory write port
//   cpu_en          CPU run enable; high once a load has completed
//   busy            load in progress
//   done            1-cycle completion pulse
//   fmt_err         sticky: a byte0 had nonzero upper bits; cleared by start
module instr_loader #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W:0]      word_count,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_wr_en,
  output logic [ADDR_W-1:0]    mem_wr_addr,
  output logic [INSTR_W-1:0]   mem_wr_data,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 fmt_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [1:0]         byte_idx;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   wcnt_inc;
  logic [CNT_W-1:0]   n_clamped;
  logic [INSTR_W-1:0] word;
  logic               xfer;

  assign xfer      = in_valid & in_ready;
  assign wcnt_inc  = wcnt + CNT_ONE;
  assign n_clamped = (word_count > DEPTH) ? DEPTH : word_count;

  // The word counter doubles as the write address. N is at most the depth,
  // so the load ends before the low bits could wrap.
  assign in_ready    = (state == S_RECV);
  assign mem_wr_en   = (state == S_WRITE);
  assign mem_wr_addr = mem_wr_en ? wcnt[ADDR_W-1:0] : '0;
  assign mem_wr_data = mem_wr_en ? word : '0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = (n_clamped == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (xfer && (byte_idx == 2'd2)) begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        state_n = (wcnt_inc == n_words) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= 2'd0;
      n_words  <= '0;
      wcnt     <= '0;
      word     <= '0;
      cpu_en   <= 1'b0;
      fmt_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_words  <= n_clamped;
            wcnt     <= '0;
            byte_idx <= 2'd0;
            word     <= '0;
            fmt_err  <= 1'b0;
            cpu_en   <= 1'b0;
          end
        end
        S_RECV: begin
          if (xfer) begin
            case (byte_idx)
              2'd0: begin
                word[17:16] <= in_data[1:0];
                // Only two bits of byte0 carry payload; anything above is malformed.
                if (in_data[7:2] != 6'd0) begin
                  fmt_err <= 1'b1;
                end
                byte_idx <= 2'd1;
              end
              2'd1: begin
                word[15:8] <= in_data;
                byte_idx   <= 2'd2;
              end
              default: begin
                word[7:0] <= in_data;
                byte_idx  <= 2'd0;
              end
            endcase
          end
        end
        S_WRITE: begin
          wcnt <= wcnt_inc;
        end
        S_DONE: begin
          cpu_en <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
